hilo_muldiv_ctrl: RTL
=====================

Name: hilo_muldiv_ctrl

Overview:
- Sequencing and result-holding stage wrapped around the iterative multiplier in the MIPS datapath.
- Accepts MULT/MULTU/MTHI/MTLO from decode/execute and converts signed operands to magnitudes.
- Drives the multiplier for a fixed latency, then captures and sign-corrects the 64-bit product into the architectural HI/LO registers.
- Stalls the pipeline while a multiply is in flight.

Parameters:
LATENCY, 33, cycles from operand launch to valid multiplier high/low outputs (2..63)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request this cycle
op_code  input  2  00 MULT (signed), 01 MULTU, 10 MTHI, 11 MTLO
rs_data  input  32  operand A, or write data for MTHI/MTLO
rt_data  input  32  operand B
rd_req  input  1  MFHI/MFLO read pending in decode
mult_start  output  1  one-cycle launch pulse to multiplier
mult_a  output  32  multiplier operand A (magnitude), held while busy
mult_b  output  32  multiplier operand B (magnitude), held while busy
mult_high  input  32  multiplier product [63:32]
mult_low  input  32  multiplier product [31:0]
busy  output  1  multiply in flight
stall  output  1  pipeline must hold
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - hi=0, lo=0, busy=0, mult_start=0, mult_a=0, mult_b=0.
  - Counter=0, neg flag=0, state IDLE.
- States: IDLE, BUSY.
- Accept rule: an op is accepted at a rising edge iff op_valid=1, state=IDLE and reset=0.
- MULTU accepted:
  - mult_a<=rs_data, mult_b<=rt_data, neg<=0.
  - mult_start=1 for the following cycle only.
  - counter<=LATENCY; state->BUSY.
- MULT accepted:
  - mult_a<=rs_data[31] ? -rs_data : rs_data; same rule for mult_b from rt_data.
  - -0x80000000 stays 0x80000000 as an unsigned magnitude.
  - neg<=rs_data[31]^rt_data[31]; otherwise identical to MULTU.
- MTHI/MTLO accepted:
  - hi<=rs_data or lo<=rs_data respectively, at that edge.
  - No state change; busy stays 0.
- BUSY behaviour:
  - counter decrements each edge.
  - At the edge where counter==1, capture P={mult_high,mult_low} and write {hi,lo}<=neg ? (~P+1) mod 2^64 : P.
  - Same edge: busy->0, state->IDLE.
  - Result: busy is high for exactly LATENCY cycles after the accept edge; the new hi/lo is visible in the first cycle busy=0.
- Output holds: mult_a/mult_b hold their values through BUSY and after, until the next accept.
- Combinational outputs:
  - busy = (state==BUSY).
  - stall = busy & (op_valid | rd_req).
  - In IDLE, stall=0.
- Ops arriving while BUSY are not accepted (stall=1). The requester holds op_valid/op_code/data until stall drops, and is then accepted on the next edge.
- Capture edge with op_valid=1: state is still BUSY at that edge, so the op is not accepted. It is accepted one edge later, after the HI/LO write; no overwrite race.
- hi/lo change only on the capture edge, an MTHI/MTLO accept, or reset. MFHI/MFLO read hi/lo directly; stall guarantees they never see a stale value mid-multiply.
- Reset mid-BUSY: at that edge, return to IDLE with all reset values. In-flight product discarded; a subsequent multiplier output is ignored.
- Width rule: all arithmetic is modulo 2^32 (operand magnitudes) or 2^64 (result negation); no overflow flags.

Test Plan:
- Assert reset 2 cycles -> hi=0, lo=0, busy=0, stall=0, mult_start=0.
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF with a behavioural LATENCY=33 multiplier model:
  - mult_start pulses exactly 1 cycle.
  - busy high 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000005 -> mult_a=3, mult_b=5; after latency hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT rs=0x80000000 rt=0x80000000 -> mult_a=mult_b=0x80000000; hi=0x40000000, lo=0x00000000.
- MTHI rs=0x12345678 during BUSY:
  - stall=1 and hi unchanged until capture.
  - Capture writes the product.
  - Next edge hi=0x12345678; lo keeps the product's low word.
- Reset asserted on cycle 10 of BUSY:
  - Next cycle busy=0, hi=lo=0.
  - Model output at cycle 33 does not alter hi/lo.
  - An immediate MULTU 2x3 then yields hi=0, lo=6.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_if.sv
// rtl/hilo_muldiv_ctrl_if.sv - request, multiplier and HI/LO signal bundle for hilo_muldiv_ctrl
interface hilo_muldiv_ctrl_if;
   logic        op_valid;
   logic [1:0]  op_code;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rd_req;
   logic        mult_start;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [31:0] mult_high;
   logic [31:0] mult_low;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport slave (
      input  op_valid, op_code, rs_data, rt_data, rd_req, mult_high, mult_low,
      output mult_start, mult_a, mult_b, busy, stall, hi, lo
   );

   modport master (
      output op_valid, op_code, rs_data, rt_data, rd_req, mult_high, mult_low,
      input  mult_start, mult_a, mult_b, busy, stall, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO sequencer around a fixed-latency unsigned multiplier
module hilo_muldiv_ctrl #(
   parameter int LATENCY = 33
) (
   input logic               clk,
   input logic               reset,
   hilo_muldiv_ctrl_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_MTHI  = 2'b10;
   localparam logic [1:0] OP_MTLO  = 2'b11;

   state_t      state;
   logic [5:0]  counter;
   logic        neg;
   logic [63:0] product;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
   assign mag_a   = bus.rs_data[31] ? (~bus.rs_data + 32'd1) : bus.rs_data;
   assign mag_b   = bus.rt_data[31] ? (~bus.rt_data + 32'd1) : bus.rt_data;
   assign product = {bus.mult_high, bus.mult_low};

   assign bus.busy  = (state == BUSY);
   assign bus.stall = bus.busy & (bus.op_valid | bus.rd_req);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         counter        <= '0;
         neg            <= 1'b0;
         bus.mult_start <= 1'b0;
         bus.mult_a     <= '0;
         bus.mult_b     <= '0;
         bus.hi         <= '0;
         bus.lo         <= '0;
      end else begin
         bus.mult_start <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.op_valid) begin
                  case (bus.op_code)
                     OP_MULT: begin
                        bus.mult_a     <= mag_a;
                        bus.mult_b     <= mag_b;
                        neg            <= bus.rs_data[31] ^ bus.rt_data[31];
                        bus.mult_start <= 1'b1;
                        counter        <= 6'(LATENCY);
                        state          <= BUSY;
                     end
                     OP_MULTU: begin
                        bus.mult_a     <= bus.rs_data;
                        bus.mult_b     <= bus.rt_data;
                        neg            <= 1'b0;
                        bus.mult_start <= 1'b1;
                        counter        <= 6'(LATENCY);
                        state          <= BUSY;
                     end
                     OP_MTHI: bus.hi <= bus.rs_data;
                     OP_MTLO: bus.lo <= bus.rs_data;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               counter <= counter - 6'd1;
               // Last busy edge: the multiplier outputs are valid now, so capture and leave BUSY together.
               if (counter == 6'd1) begin
                  {bus.hi, bus.lo} <= neg ? (~product + 64'd1) : product;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
